axi_wr_burst_ctrl: RTL
======================

// Module: axi_wr_burst_ctrl
// PURPOSE
//  Downstream of the AXI write interface: turns its latched burst descriptor and per-beat data pulses into
//  local SRAM byte-masked writes, generating the per-beat address for FIXED/INCR/WRAP bursts.
//  Returns axi_transfer_done per beat (re-opens WREADY upstream) and produces the B-channel response.
// PARAMETERS
//  ADDR_WIDTH   11  byte-address width of descriptor (axi_wr_addr)
//  DATA_WIDTH   32  beat/SRAM word width, bits; power of two, >=8
//  STRB_WIDTH   4   DATA_WIDTH/8
//  SRAM_AW      9   SRAM word-address width = ADDR_WIDTH-log2(STRB_WIDTH)
//  ID_WIDTH     8   BID width
// PORTS
//  clk                input   1           clock, all logic on rising edge
//  rst_n              input   1           asynchronous active-low reset
//  axi_wr_doing       input   1           burst in progress; rising edge = new descriptor valid
//  axi_wr_addr        input   ADDR_WIDTH  burst start byte address
//  axi_wr_burst       input   2           00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  axi_wr_size        input   3           bytes/beat = 1<<size
//  axi_wr_len         input   8           beats-1
//  axi_wr_vld         input   1           one-cycle pulse per beat
//  axi_wr_data        input   DATA_WIDTH  beat data, valid with axi_wr_vld
//  axi_wr_strb        input   STRB_WIDTH  byte strobes, valid with axi_wr_vld
//  axi_transfer_done  output  1           one-cycle pulse: beat consumed
//  sram_we            output  1           SRAM write enable
//  sram_addr          output  SRAM_AW     SRAM word address
//  sram_wdata         output  DATA_WIDTH  SRAM write data
//  sram_bmask         output  STRB_WIDTH  SRAM byte write mask
//  BID                output  ID_WIDTH    constant `TPU_ID
//  BRESP              output  2           00 OKAY, 10 SLVERR
//  BVALID             output  1           response valid
//  BREADY             input   1           response accepted
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0 except BID; addr/beat counters 0, err 0.
//  FSM: IDLE -(axi_wr_doing rises, 0->1)-> LOAD -> DATA -(last beat consumed)-> RESP -(BVALID&BREADY)-> IDLE.
//  LOAD: capture addr,burst,size,len; beat_cnt=0; err=(size>log2(STRB_WIDTH))|(burst==11)|WRAP-len-illegal.
//  DATA: each axi_wr_vld -> next cycle: transfer_done=1, sram_we=~err, addr/data/bmask registered (latency 1).
//   bmask=axi_wr_strb; sram_addr=cur_addr>>log2(STRB_WIDTH). beat_cnt++; last when beat_cnt==len.
//  Next addr: FIXED hold; INCR cur+(1<<size), mod 2^ADDR_WIDTH (wraps to 0 at top, no error);
//   WRAP: blk=(len+1)<<size, base=cur&~(blk-1), next=base|((cur+(1<<size))&(blk-1)); len must be 1,3,7,15.
//   INCR from unaligned start: first beat uses start addr, later beats aligned to 1<<size.
//  RESP: BVALID=1 held until BREADY; BRESP=err?10:00; drops the cycle after handshake; no new LOAD before.
//  axi_wr_vld outside DATA (IDLE/LOAD/RESP): transfer_done still pulsed next cycle (no upstream hang), no write.
//  Error bursts: all beats consumed and acknowledged, no SRAM write, SLVERR at end.
//  axi_wr_doing falling mid-DATA: ignored; burst ends only on beat count.
// CONFIGURATION
//  AXI_WR_WRAP_EN defined: WRAP bursts executed as above.
//  Not defined: burst==10 sets err -> beats consumed, no writes, BRESP=SLVERR; wrap logic not synthesized.
// STRUCTURE
//  Shared package axi_wr_defs.vh: BURST_FIXED/INCR/WRAP, RESP_OKAY/RESP_SLVERR, `TPU_ID, FSM state encodings.
//  Sub-module axi_burst_addr_gen: combinational next-address (cur,size,len,burst)->next; reusable by read path.
// TESTING
//  INCR addr=0x010 size=2 len=3, strb=F -> sram_addr 4,5,6,7, we 1 cycle after each vld, BRESP=00.
//  FIXED addr=0x020 len=2 strb 1,2,4 -> sram_addr 8 x3, bmask 1,2,4, three transfer_done pulses.
//  WRAP (EN) addr=0x018 size=2 len=3 -> sram_addr 6,7,4,5; without EN -> no we, BRESP=10.
//  size=3 (>4B) len=1 -> 2 transfer_done, sram_we never 1, BRESP=10, BVALID held 5 cycles with BREADY=0.
//  INCR addr=0x7FC size=2 len=1 -> sram_addr 0x1FF then 0x000, BRESP=00.
//  rst_n low mid-DATA (beat 2 of 4) -> all outputs 0 immediately; next burst from IDLE completes normally.

Source files
------------

// File: rtl/axi_wr_burst_ctrl_pkg.sv
// Shared definitions for the AXI write burst controller and its address generator.
// WRAP execution is enabled by defining AXI_WR_WRAP_EN.
package axi_wr_burst_ctrl_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] TPU_ID = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } wr_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// WRAP arithmetic only exists when AXI_WR_WRAP_EN is defined.
module axi_burst_addr_gen
  import axi_wr_burst_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [ADDR_WIDTH-1:0] cur_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;

  assign step = ADDR_WIDTH'(1) << size_i;
  // Align down first so an unaligned INCR start snaps to the beat grid.
  assign incr = (cur_i & ~(step - ADDR_WIDTH'(1))) + step;

`ifdef AXI_WR_WRAP_EN
  logic [15:0]           blk;
  logic [ADDR_WIDTH-1:0] msk;
  logic [ADDR_WIDTH-1:0] wrap;

  assign blk  = ({8'd0, len_i} + 16'd1) << size_i;
  assign msk  = ADDR_WIDTH'(blk - 16'd1);
  assign wrap = (cur_i & ~msk) | ((cur_i + step) & msk);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    next_o = cur_i;
    unique case (1'b1)
      (burst_i == BURST_INCR): next_o = incr;
`ifdef AXI_WR_WRAP_EN
      (burst_i == BURST_WRAP): next_o = wrap;
`endif
      default: next_o = cur_i;
    endcase
  end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// AXI write burst -> SRAM byte-masked writes, per-beat ack and B response.
// Define AXI_WR_WRAP_EN to execute WRAP bursts; otherwise they end in SLVERR.
module axi_wr_burst_ctrl
  import axi_wr_burst_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int SRAM_AW    = 9,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  axi_wr_doing,
  input  logic [ADDR_WIDTH-1:0] axi_wr_addr,
  input  logic [1:0]            axi_wr_burst,
  input  logic [2:0]            axi_wr_size,
  input  logic [7:0]            axi_wr_len,
  input  logic                  axi_wr_vld,
  input  logic [DATA_WIDTH-1:0] axi_wr_data,
  input  logic [STRB_WIDTH-1:0] axi_wr_strb,
  output logic                  axi_transfer_done,
  output logic                  sram_we,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [STRB_WIDTH-1:0] sram_bmask,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY
);

  localparam int OFFW = $clog2(STRB_WIDTH);

  wr_state_e             state_q;
  logic                  doing_q;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic                  done_q;
  logic                  we_q;
  logic [SRAM_AW-1:0]    addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] bmask_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  rise_d;
  logic                  load_err_d;
  logic                  wrap_err_d;
  logic [ADDR_WIDTH-1:0] next_d;

  assign rise_d = axi_wr_doing & ~doing_q;

`ifdef AXI_WR_WRAP_EN
  assign wrap_err_d = (axi_wr_burst == BURST_WRAP) &&
                      !wrap_len_ok(axi_wr_len);
`else
  assign wrap_err_d = (axi_wr_burst == BURST_WRAP);
`endif

  assign load_err_d = (axi_wr_size > 3'(OFFW)) ||
                      (axi_wr_burst == BURST_RSVD) ||
                      wrap_err_d;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_agen (
    .cur_i  (cur_q),
    .size_i (size_q),
    .len_i  (len_q),
    .burst_i(burst_q),
    .next_o (next_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      doing_q  <= 1'b0;
      pend_q   <= 1'b0;
      cur_q    <= '0;
      burst_q  <= '0;
      size_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      doing_q <= axi_wr_doing;
      // Every beat is acked so upstream never stalls, even outside DATA.
      done_q  <= axi_wr_vld;
      we_q    <= 1'b0;
      if (state_q != S_IDLE && rise_d) pend_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (rise_d || pend_q) begin
            pend_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          cur_q   <= axi_wr_addr;
          burst_q <= axi_wr_burst;
          size_q  <= axi_wr_size;
          len_q   <= axi_wr_len;
          cnt_q   <= '0;
          err_q   <= load_err_d;
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (axi_wr_vld) begin
            we_q    <= ~err_q;
            addr_q  <= cur_q[ADDR_WIDTH-1:OFFW];
            wdata_q <= axi_wr_data;
            bmask_q <= axi_wr_strb;
            cur_q   <= next_d;
            cnt_q   <= cnt_q + 8'd1;
            if (cnt_q == len_q) begin
              bvalid_q <= 1'b1;
              bresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
              state_q  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (BREADY) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axi_transfer_done = done_q;
  assign sram_we           = we_q;
  assign sram_addr         = addr_q;
  assign sram_wdata        = wdata_q;
  assign sram_bmask        = bmask_q;
  assign BVALID            = bvalid_q;
  assign BRESP             = bresp_q;
  assign BID               = ID_WIDTH'(TPU_ID);

endmodule
